des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key-schedule generator. It takes a 64-bit key and applies PC-1. It then walks the 28-bit C/D halves through the 16-round rotation schedule and emits one 48-bit PC-2 subkey per accepted handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits between the key register and the DES round datapath, and supersedes the standalone PC-1 stage with a full schedule, decrypt mode, downstream backpressure and optional key-parity checking.

## Interface
- PARITY_CHK, 1, when 1, check DES odd parity per key byte at load; when 0, parity_err is tied 0.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  load request; accepted only when ready=1.
- decrypt  in  1  mode, sampled with start: 0 gives K1..K16, 1 gives K16..K1.
- key  in  64  DES key, MSB-first: DES bit n = key[64-n]; parity bits key[56], key[48], ..., key[0] are excluded from PC-1.
- ready  out  1  idle, can accept start.
- subkey_valid  out  1  subkey/round are valid.
- subkey_ready  in  1  downstream accepts current subkey.
- subkey  out  48  PC-2 output, MSB-first: DES bit 1 = subkey[47].
- round  out  4  DES round index of current subkey minus 1 (K1 = 0, K16 = 15).
- last  out  1  subkey_valid and current subkey is the 16th emitted.
- parity_err  out  1  sticky per job: set at load if any key byte has even parity.

## Operation
- States: IDLE, RUN.
- Registers: C[27:0], D[27:0], step counter (0..15), mode bit, parity_err.
- Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE:
  - ready=1, subkey_valid=0.
  - On start (edge E0): load {C,D} = PC-1(key), then apply the first step, latch decrypt, step=0, compute parity_err, go to RUN.
  - First step in encrypt mode is rotate-left by S[1].
  - First step in decrypt mode is no shift, because C16D16 = C0D0 after 28 total shifts.
- RUN:
  - ready=0, subkey_valid=1, subkey = PC-2(C,D), fed combinationally from the registers.
  - round = step when encrypting, 15-step when decrypting.
  - On an edge with subkey_ready=1:
    - If step=15, go to IDLE.
    - Otherwise step+1 and rotate by the next step's amount.
    - Encrypt rotates C and D independently left by S[step+2].
    - Decrypt rotates right by S[16-step] (1-based).
  - subkey_ready=0 stalls: all registers hold, outputs stable.
- start while RUN is ignored. key and decrypt are don't-care after acceptance.
- start in the same cycle as the final handshake is not accepted, because ready=0 that cycle. The next job can start one cycle later.
- parity_err:
  - Cleared at each accepted start.
  - Set from the new key in the same edge.
  - Holds until the next start.
  - Informational only; the schedule still runs.
- Reset (any time, including mid-RUN) forces IDLE and clears C, D, step, mode and parity_err.

## Timing
- Reset values: ready=1, subkey_valid=0, subkey=0 (PC-2 of zero), round=0, last=0, parity_err=0.
- Latency: start accepted at edge E0 gives subkey_valid=1 and the first subkey from E0 onward (1 cycle).
- With subkey_ready held at 1, the 16 subkeys take 16 consecutive cycles. ready returns to 1 after the 16th handshake edge.
- Minimum job period is 17 cycles.
- Outputs depend only on registers; there is no combinational path from inputs to outputs.
- Exception: none. Note that last is registered-derived.

## Structure
- Package des_pkg holds:
  - PC-1 and PC-2 as functions with fixed bit maps.
  - The shift schedule constant S.
  - A rotate-by-1/2 function for 28-bit values.
  - The state enum {IDLE, RUN}.
- One sub-module, des_pc2: purely combinational 56-to-48 PC-2, reused by the round datapath for verification taps.
- PC-1, the rotate logic, the counter and the FSM stay in des_key_schedule.

## Test plan
- Encrypt, key 133457799BBCDFF1, subkey_ready=1:
  - First subkey 1B02EFFC7072 with round=0.
  - 16th subkey CB3D8B0E17F5 with round=15 and last=1.
  - ready=1 the following cycle; parity_err=0.
- Decrypt, same key:
  - First subkey CB3D8B0E17F5 with round=15.
  - Final subkey 1B02EFFC7072 with round=0 and last=1.
  - The full sequence is the exact reverse of the encrypt run.
- Backpressure: random subkey_ready toggling during the encrypt run.
  - subkey and round hold while subkey_ready=0.
  - Same 16-value sequence as the unstalled run; no skips or duplicates.
- Parity:
  - key 0000000000000000 gives parity_err=1 from E0; schedule still runs 16 subkeys.
  - Next start with 133457799BBCDFF1 clears it.
  - With PARITY_CHK=0, parity_err stays 0.
- Busy/start collision: pulse start with a different key at step 5.
  - Ignored; the sequence continues unchanged.
  - start asserted in the final-handshake cycle is not accepted.
- Reset mid-RUN: assert rst at step 7.
  - Immediately ready=1, subkey_valid=0, subkey=0, round=0, parity_err=0.
  - After release, a new start yields a correct K1 one cycle later.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule permutation tables, shift schedule, rotate helpers, FSM state type
package des_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC-1: 1-based DES key bit numbers, C half first then D half
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: 1-based bit numbers into the 56-bit C||D concatenation
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount per round, index 0 is round 1
    localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // DES bit n lives at key[64-n]; result bit n lives at cd[56-n]
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[64-PC1_TAB[i]];
        end
        return cd;
    endfunction

    // C||D bit n lives at cd[56-n]; subkey bit n lives at k[48-n]
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[47-i] = cd[56-PC2_TAB[i]];
        end
        return k;
    endfunction

    function automatic logic shift_is_two(input logic [3:0] idx);
        return (SHIFT_SCHED[idx] == 2);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // A DES key byte is well-formed when it has an odd number of ones
    function automatic logic key_parity_err(input logic [63:0] key);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (~^key[b*8 +: 8]) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational 56-to-48 PC-2 permutation
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_k
);

    assign o_k = pc2(i_cd);

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES subkey generator with encrypt/decrypt order and backpressure
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit PARITY_CHK = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        ready,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        last,
    output logic        parity_err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_step;
    logic        r_mode;
    logic        r_parity_err;

    logic        w_load;
    logic        w_adv;
    logic        w_final;
    logic [55:0] w_pc1;
    logic [3:0]  w_shift_idx;
    logic [27:0] w_c_nxt;
    logic [27:0] w_d_nxt;
    logic        w_par;
    logic [47:0] w_subkey;

    assign w_load  = (r_state == IDLE) && start;
    assign w_adv   = (r_state == RUN) && subkey_ready;
    assign w_final = w_adv && (r_step == 4'd15);
    assign w_pc1   = pc1(key);
    assign w_par   = PARITY_CHK ? key_parity_err(key) : 1'b0;

    // Next C/D: load applies the first step; decrypt starts at C16D16 which equals C0D0
    always_comb begin
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_shift_idx = 4'd0;
        if (w_load) begin
            if (decrypt) begin
                w_c_nxt = w_pc1[55:28];
                w_d_nxt = w_pc1[27:0];
            end else begin
                w_c_nxt = rotl28(w_pc1[55:28], shift_is_two(4'd0));
                w_d_nxt = rotl28(w_pc1[27:0], shift_is_two(4'd0));
            end
        end else if (w_adv && !w_final) begin
            if (r_mode) begin
                w_shift_idx = 4'd15 - r_step;
                w_c_nxt     = rotr28(r_c, shift_is_two(w_shift_idx));
                w_d_nxt     = rotr28(r_d, shift_is_two(w_shift_idx));
            end else begin
                w_shift_idx = r_step + 4'd1;
                w_c_nxt     = rotl28(r_c, shift_is_two(w_shift_idx));
                w_d_nxt     = rotl28(r_d, shift_is_two(w_shift_idx));
            end
        end
    end

    // Next state: a job ends on the handshake of the 16th subkey
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)   w_state_nxt = RUN;
            RUN:     if (w_final) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key halves, step counter, mode and sticky parity flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c          <= '0;
            r_d          <= '0;
            r_step       <= '0;
            r_mode       <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_c <= w_c_nxt;
            r_d <= w_d_nxt;
            if (w_load) begin
                r_step       <= 4'd0;
                r_mode       <= decrypt;
                r_parity_err <= w_par;
            end else if (w_final) begin
                r_step <= 4'd0;
            end else if (w_adv) begin
                r_step <= r_step + 4'd1;
            end
        end
    end

    des_pc2 u_pc2 (
        .i_cd ({r_c, r_d}),
        .o_k  (w_subkey)
    );

    assign ready        = (r_state == IDLE);
    assign subkey_valid = (r_state == RUN);
    assign subkey       = w_subkey;
    assign round        = r_mode ? (4'd15 - r_step) : r_step;
    assign last         = (r_state == RUN) && (r_step == 4'd15);
    assign parity_err   = r_parity_err;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - directed self-checking bench for des_key_schedule
module tb_des_key_schedule;

    localparam logic [63:0] KEY_GOOD   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_ZERO   = 64'h0000000000000000;
    localparam logic [63:0] KEY_BADPAR = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY_OTHER  = 64'h0E329232EA6D0D73;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        subkey_ready;
    logic        ready;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        last;
    logic        parity_err;

    logic        np_ready;
    logic        np_subkey_valid;
    logic [47:0] np_subkey;
    logic [3:0]  np_round;
    logic        np_last;
    logic        np_parity_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [47:0] exp_k [16];

    always #5 clk = ~clk;

    des_key_schedule #(.PARITY_CHK(1'b1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .ready        (ready),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round        (round),
        .last         (last),
        .parity_err   (parity_err)
    );

    des_key_schedule #(.PARITY_CHK(1'b0)) u_dut_np (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .ready        (np_ready),
        .subkey_valid (np_subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (np_subkey),
        .round        (np_round),
        .last         (np_last),
        .parity_err   (np_parity_err)
    );

    // Present a key at a negedge; returns at the negedge after the accepting edge
    task automatic launch_job(input logic [63:0] k, input logic dec);
        @(negedge clk);
        start        = 1'b1;
        key          = k;
        decrypt      = dec;
        subkey_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        key     = KEY_OTHER;
        decrypt = ~dec;
    endtask

    task automatic test_reset;
        rst          = 1'b0;
        start        = 1'b0;
        decrypt      = 1'b0;
        key          = '0;
        subkey_ready = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || subkey_valid !== 1'b0 || subkey !== 48'h0 || round !== 4'd0
            || last !== 1'b0 || parity_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: got ready=%b valid=%b subkey=%h round=%0d last=%b perr=%b, expected 1 0 0 0 0 0",
                     ready, subkey_valid, subkey, round, last, parity_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_encrypt;
        launch_job(KEY_GOOD, 1'b0);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (subkey !== exp_k[i] || round !== i[3:0] || subkey_valid !== 1'b1 || ready !== 1'b0
                || last !== (i == 15)) begin
                n_errors++;
                $display("FAIL enc_k%0d: got subkey=%h round=%0d valid=%b ready=%b last=%b, expected subkey=%h round=%0d valid=1 ready=0 last=%b",
                         i + 1, subkey, round, subkey_valid, ready, last, exp_k[i], i, (i == 15));
            end
            @(negedge clk);
        end
        n_checks++;
        if (ready !== 1'b1 || subkey_valid !== 1'b0 || parity_err !== 1'b0) begin
            n_errors++;
            $display("FAIL enc_done: got ready=%b valid=%b perr=%b, expected 1 0 0", ready, subkey_valid, parity_err);
        end
    endtask

    task automatic test_decrypt;
        launch_job(KEY_GOOD, 1'b1);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (subkey !== exp_k[15-i] || round !== 4'(15 - i) || subkey_valid !== 1'b1
                || last !== (i == 15)) begin
                n_errors++;
                $display("FAIL dec_step%0d: got subkey=%h round=%0d valid=%b last=%b, expected subkey=%h round=%0d valid=1 last=%b",
                         i, subkey, round, subkey_valid, last, exp_k[15-i], 15 - i, (i == 15));
            end
            @(negedge clk);
        end
        n_checks++;
        if (ready !== 1'b1 || subkey_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL dec_done: got ready=%b valid=%b, expected 1 0", ready, subkey_valid);
        end
    endtask

    task automatic test_backpressure;
        int   idx;
        int   cyc;
        logic rdy;
        idx = 0;
        cyc = 0;
        launch_job(KEY_GOOD, 1'b0);
        while (idx < 16 && cyc < 200) begin
            n_checks++;
            if (subkey !== exp_k[idx] || round !== idx[3:0] || subkey_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_cyc%0d: got subkey=%h round=%0d valid=%b, expected subkey=%h round=%0d valid=1",
                         cyc, subkey, round, subkey_valid, exp_k[idx], idx);
            end
            rdy = (cyc % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            subkey_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        subkey_ready = 1'b1;
        n_checks++;
        if (idx != 16 || ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_done: got handshakes=%0d ready=%b, expected 16 1", idx, ready);
        end
    endtask

    task automatic test_parity;
        launch_job(KEY_ZERO, 1'b0);
        n_checks++;
        if (parity_err !== 1'b1 || np_parity_err !== 1'b0) begin
            n_errors++;
            $display("FAIL par_set: got perr=%b np_perr=%b, expected 1 0", parity_err, np_parity_err);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (subkey !== 48'h0 || subkey_valid !== 1'b1 || last !== (i == 15)) begin
                n_errors++;
                $display("FAIL par_run%0d: got subkey=%h valid=%b last=%b, expected 0 1 %b",
                         i, subkey, subkey_valid, last, (i == 15));
            end
            @(negedge clk);
        end
        n_checks++;
        if (parity_err !== 1'b1 || ready !== 1'b1 || np_parity_err !== 1'b0) begin
            n_errors++;
            $display("FAIL par_hold: got perr=%b ready=%b np_perr=%b, expected 1 1 0", parity_err, ready, np_parity_err);
        end
        launch_job(KEY_GOOD, 1'b0);
        n_checks++;
        if (parity_err !== 1'b0 || subkey !== exp_k[0]) begin
            n_errors++;
            $display("FAIL par_clear: got perr=%b subkey=%h, expected 0 %h", parity_err, subkey, exp_k[0]);
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_collision;
        launch_job(KEY_GOOD, 1'b0);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (subkey !== exp_k[i] || round !== i[3:0] || last !== (i == 15)) begin
                n_errors++;
                $display("FAIL col_k%0d: got subkey=%h round=%0d last=%b, expected subkey=%h round=%0d last=%b",
                         i + 1, subkey, round, last, exp_k[i], i, (i == 15));
            end
            if (i == 5) begin
                start   = 1'b1;
                key     = KEY_ZERO;
                decrypt = 1'b1;
            end else if (i == 15) begin
                start   = 1'b1;
                key     = KEY_ZERO;
                decrypt = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (ready !== 1'b1 || subkey_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL col_final_start: got ready=%b valid=%b, expected 1 0", ready, subkey_valid);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (subkey_valid !== 1'b1 || subkey !== 48'h0 || round !== 4'd0 || parity_err !== 1'b1) begin
            n_errors++;
            $display("FAIL col_next_job: got valid=%b subkey=%h round=%0d perr=%b, expected 1 0 0 1",
                     subkey_valid, subkey, round, parity_err);
        end
        repeat (16) @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL col_drain: got ready=%b, expected 1", ready);
        end
    endtask

    task automatic test_reset_midrun;
        launch_job(KEY_BADPAR, 1'b0);
        n_checks++;
        if (subkey !== exp_k[0] || parity_err !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre: got subkey=%h perr=%b, expected %h 1", subkey, parity_err, exp_k[0]);
        end
        repeat (7) @(negedge clk);
        n_checks++;
        if (subkey !== exp_k[7] || round !== 4'd7) begin
            n_errors++;
            $display("FAIL rst_step7: got subkey=%h round=%0d, expected %h 7", subkey, round, exp_k[7]);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || subkey_valid !== 1'b0 || subkey !== 48'h0 || round !== 4'd0
            || parity_err !== 1'b0 || last !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: got ready=%b valid=%b subkey=%h round=%0d perr=%b last=%b, expected 1 0 0 0 0 0",
                     ready, subkey_valid, subkey, round, parity_err, last);
        end
        @(negedge clk);
        rst = 1'b1;
        launch_job(KEY_GOOD, 1'b0);
        n_checks++;
        if (subkey !== exp_k[0] || round !== 4'd0 || subkey_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_restart: got subkey=%h round=%0d valid=%b, expected %h 0 1",
                     subkey, round, subkey_valid, exp_k[0]);
        end
        repeat (16) @(negedge clk);
    endtask

    initial begin
        exp_k[0]  = 48'h1B02EFFC7072;
        exp_k[1]  = 48'h79AED9DBC9E5;
        exp_k[2]  = 48'h55FC8A42CF99;
        exp_k[3]  = 48'h72ADD6DB351D;
        exp_k[4]  = 48'h7CEC07EB53A8;
        exp_k[5]  = 48'h63A53E507B2F;
        exp_k[6]  = 48'hEC84B7F618BC;
        exp_k[7]  = 48'hF78A3AC13BFB;
        exp_k[8]  = 48'hE0DBEBEDE781;
        exp_k[9]  = 48'hB1F347BA464F;
        exp_k[10] = 48'h215FD3DED386;
        exp_k[11] = 48'h7571F59467E9;
        exp_k[12] = 48'h97C5D1FABA41;
        exp_k[13] = 48'h5F43B7F2E73A;
        exp_k[14] = 48'hBF918D3D3F0A;
        exp_k[15] = 48'hCB3D8B0E17F5;

        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_parity();
        test_collision();
        test_reset_midrun();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
